// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the parametrised write-back data cache.
package dcache_pkg;

    localparam int unsigned DEF_ADDR_W          = 8;
    localparam int unsigned DEF_DATA_W          = 8;
    localparam int unsigned DEF_WORDS_PER_BLOCK = 2;
    localparam int unsigned DEF_LINES           = 8;
    localparam int unsigned DEF_CNT_W           = 16;

    localparam int unsigned OFF_W = $clog2(DEF_WORDS_PER_BLOCK);
    localparam int unsigned IDX_W = $clog2(DEF_LINES);
    localparam int unsigned TAG_W = DEF_ADDR_W - OFF_W - IDX_W;
    localparam int unsigned BLK_W = DEF_DATA_W * DEF_WORDS_PER_BLOCK;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        FLUSH_SCAN,
        FLUSH_WB
    } state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Data/tag/valid/dirty arrays: combinational lookup, synchronous word or block write.
module dcache_line_store #(
    parameter int unsigned LINES           = 8,
    parameter int unsigned WORDS_PER_BLOCK = 2,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned IDX_BITS        = 3,
    parameter int unsigned TAG_BITS        = 4,
    parameter int unsigned OFF_BITS        = 1,
    parameter int unsigned BLK_BITS        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] idx,
    output logic [TAG_BITS-1:0] tag,
    output logic                valid,
    output logic                dirty,
    output logic [BLK_BITS-1:0] block,
    input  logic                word_we,
    input  logic [OFF_BITS-1:0] word_off,
    input  logic [DATA_W-1:0]   word_data,
    input  logic                block_we,
    input  logic [TAG_BITS-1:0] block_tag,
    input  logic [BLK_BITS-1:0] block_data,
    input  logic                dirty_clr
);

    logic [BLK_BITS-1:0] data_q [LINES];
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;

    assign tag   = tag_q[idx];
    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign block = data_q[idx];

    // Payload arrays carry no reset; contents are qualified by valid.
    always_ff @(posedge clk) begin
        if (block_we) begin
            data_q[idx] <= block_data;
            tag_q[idx]  <= block_tag;
        end else if (word_we) begin
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
                if (word_off == OFF_BITS'(w)) begin
                    data_q[idx][w*DATA_W +: DATA_W] <= word_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (block_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end else if (dirty_clr) begin
            dirty_q[idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_wb_param.sv
// Direct-mapped write-back/write-allocate data cache with flush and hit/miss statistics.
module dcache_wb_param
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W          = DEF_ADDR_W,
    parameter int unsigned DATA_W          = DEF_DATA_W,
    parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int unsigned LINES           = DEF_LINES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    localparam int unsigned OFF_BITS = $clog2(WORDS_PER_BLOCK),
    localparam int unsigned IDX_BITS = $clog2(LINES),
    localparam int unsigned TAG_BITS = ADDR_W - OFF_BITS - IDX_BITS,
    localparam int unsigned BLK_BITS = DATA_W * WORDS_PER_BLOCK,
    localparam int unsigned MADDR_W  = TAG_BITS + IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   read_data,
    output logic                busy_wait,
    input  logic                flush,
    output logic                flush_done,
    output logic                mem_read,
    output logic                mem_write,
    output logic [MADDR_W-1:0]  mem_address,
    output logic [BLK_BITS-1:0] mem_write_data,
    input  logic [BLK_BITS-1:0] mem_read_data,
    input  logic                mem_ready,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    state_e state_q, state_d;
    logic [IDX_BITS-1:0] scan_q, scan_d;
    logic                refill_q;

    logic [OFF_BITS-1:0] off_a;
    logic [IDX_BITS-1:0] idx_a, ln_idx;
    logic [TAG_BITS-1:0] tag_a, ln_tag;
    logic                ln_valid, ln_dirty;
    logic [BLK_BITS-1:0] ln_block;
    logic [DATA_W-1:0]   ln_word;
    logic                req, hit, in_flush;
    logic                word_we, block_we, dirty_clr, done_d, hit_inc, miss_inc;
    logic                mem_read_d, mem_write_d;
    logic [MADDR_W-1:0]  mem_address_d;
    logic [BLK_BITS-1:0] mem_write_data_d;

    assign off_a    = address[OFF_BITS-1:0];
    assign idx_a    = address[OFF_BITS +: IDX_BITS];
    assign tag_a    = address[ADDR_W-1 -: TAG_BITS];
    assign in_flush = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WB);
    assign ln_idx   = in_flush ? scan_q : idx_a;
    // read and write together is an illegal encoding and counts as no request
    assign req      = read ^ write;
    assign hit      = ln_valid && (ln_tag == tag_a);

    dcache_line_store #(
        .LINES(LINES), .WORDS_PER_BLOCK(WORDS_PER_BLOCK), .DATA_W(DATA_W),
        .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .OFF_BITS(OFF_BITS), .BLK_BITS(BLK_BITS)
    ) u_store (
        .clk(clk), .rst(rst), .idx(ln_idx),
        .tag(ln_tag), .valid(ln_valid), .dirty(ln_dirty), .block(ln_block),
        .word_we(word_we), .word_off(off_a), .word_data(write_data),
        .block_we(block_we), .block_tag(tag_a), .block_data(mem_read_data),
        .dirty_clr(dirty_clr)
    );

    always_comb begin
        ln_word = '0;
        for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
            if (off_a == OFF_BITS'(w)) ln_word = ln_block[w*DATA_W +: DATA_W];
        end
    end

    assign busy_wait = (state_q != IDLE) || (req && !hit);
    assign read_data = (state_q == IDLE && read && !write && hit) ? ln_word : '0;

    // Next-state, array write enables and next values of the registered memory port.
    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        word_we   = 1'b0;
        block_we  = 1'b0;
        dirty_clr = 1'b0;
        done_d    = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_inc = 1'b1;
                    state_d  = ln_dirty ? WRITEBACK : ALLOCATE;
                end else if (req) begin
                    word_we = write;
                    hit_inc = !refill_q;
                end else if (flush && !read && !write) begin
                    scan_d  = '0;
                    state_d = FLUSH_SCAN;
                end
            end
            WRITEBACK: if (mem_ready) begin
                dirty_clr = 1'b1;
                state_d   = ALLOCATE;
            end
            ALLOCATE: if (mem_ready) begin
                block_we = 1'b1;
                state_d  = IDLE;
            end
            FLUSH_SCAN: begin
                if (ln_dirty) begin
                    state_d = FLUSH_WB;
                end else if (scan_q == IDX_BITS'(LINES - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    scan_d = scan_q + IDX_BITS'(1);
                end
            end
            FLUSH_WB: if (mem_ready) begin
                dirty_clr = 1'b1;
                state_d   = FLUSH_SCAN;
            end
            default: state_d = IDLE;
        endcase

        mem_read_d       = (state_d == ALLOCATE);
        mem_write_d      = (state_d == WRITEBACK) || (state_d == FLUSH_WB);
        mem_address_d    = '0;
        mem_write_data_d = '0;
        if (mem_read_d) begin
            mem_address_d = {tag_a, idx_a};
        end else if (mem_write_d) begin
            mem_address_d    = {ln_tag, ln_idx};
            mem_write_data_d = ln_block;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            scan_q         <= '0;
            refill_q       <= 1'b0;
            flush_done     <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            state_q        <= state_d;
            scan_q         <= scan_d;
            refill_q       <= block_we;
            flush_done     <= done_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            mem_address    <= mem_address_d;
            mem_write_data <= mem_write_data_d;
            if (hit_inc && hit_count != '1)   hit_count  <= hit_count + CNT_W'(1);
            if (miss_inc && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dcache_wb_param.sv
// Directed bench for dcache_wb_param: misses, hits, eviction, flush, reset, saturation.
module tb_dcache_wb_param;
    import dcache_pkg::*;

    localparam int unsigned MA_W = TAG_W + IDX_W;

    logic                  clk, rst, read, write, flush, mem_ready;
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_DATA_W-1:0] write_data, read_data;
    logic                  busy_wait, flush_done, mem_read, mem_write;
    logic [MA_W-1:0]       mem_address;
    logic [BLK_W-1:0]      mem_write_data, mem_read_data;
    logic [DEF_CNT_W-1:0]  hit_count, miss_count;

    logic [DEF_DATA_W-1:0] s_read_data;
    logic                  s_busy_wait, s_flush_done, s_mem_read, s_mem_write;
    logic [MA_W-1:0]       s_mem_address;
    logic [BLK_W-1:0]      s_mem_write_data;
    logic [1:0]            s_hit_count, s_miss_count;

    dcache_wb_param u_dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .write_data(write_data), .read_data(read_data), .busy_wait(busy_wait),
        .flush(flush), .flush_done(flush_done), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    dcache_wb_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .write_data(write_data), .read_data(s_read_data), .busy_wait(s_busy_wait),
        .flush(flush), .flush_done(s_flush_done), .mem_read(s_mem_read), .mem_write(s_mem_write),
        .mem_address(s_mem_address), .mem_write_data(s_mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    typedef struct {
        bit               wr;
        logic [MA_W-1:0]  addr;
        logic [BLK_W-1:0] data;
    } txn_t;

    logic [BLK_W-1:0] mem [2**(DEF_ADDR_W-OFF_W)];
    txn_t log_q[$];
    bit   mem_stall, mem_seen;
    int   done_cnt, both_cnt;
    int   n_checks, n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: ready one cycle after a request is first seen.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (rst || mem_stall || !(mem_read || mem_write)) begin
            mem_seen = 1'b0;
        end else if (!mem_seen) begin
            mem_seen = 1'b1;
        end else begin
            if (mem_write) mem[mem_address] = mem_write_data;
            else           mem_read_data = mem[mem_address];
            log_q.push_back('{wr: mem_write, addr: mem_address, data: mem_write_data});
            mem_ready = 1'b1;
            mem_seen  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (flush_done) done_cnt++;
        if (mem_read && mem_write) both_cnt++;
    end

    task automatic cpu_access(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                              output int stalls, output logic [7:0] rd);
        @(negedge clk);
        address = addr; write_data = wd; read = !wr; write = wr;
        #1;
        stalls = 0;
        while (busy_wait && stalls < 50) begin
            @(negedge clk); #1;
            stalls++;
        end
        rd = read_data;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    int          st;
    logic [7:0]  rd;

    initial begin
        n_checks = 0; n_errors = 0; done_cnt = 0; both_cnt = 0;
        mem_stall = 1'b0; mem_seen = 1'b0; mem_ready = 1'b0; mem_read_data = '0;
        rst = 1'b1; read = 1'b0; write = 1'b0; flush = 1'b0; address = '0; write_data = '0;
        for (int i = 0; i < 2**(DEF_ADDR_W-OFF_W); i++) mem[i] = '0;
        mem[7'h0C] = 16'h2D00;
        mem[7'h1C] = 16'hA55A;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy_wait, 0);
        check("rst_rdata", read_data, 0);
        check("rst_mem_rw", {mem_read, mem_write, flush_done}, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_counts", {hit_count, miss_count}, 0);
        rst = 1'b0;

        // Clean read miss on 0x19 fetches block 0x0C.
        cpu_access(1'b0, 8'h19, 8'h00, st, rd);
        check("t1_stall", st, 3);
        check("t1_rdata", rd, 8'h2D);
        check("t1_miss", miss_count, 1);
        check("t1_hit", hit_count, 0);
        check("t1_log_n", log_q.size(), 1);
        if (log_q.size() > 0) check("t1_fetch", {31'(log_q[0].wr), 1'b0} | 32'(log_q[0].addr), 32'h0C);

        // Write hit then read hit.
        cpu_access(1'b1, 8'h19, 8'h41, st, rd);
        check("t2_wstall", st, 0);
        cpu_access(1'b0, 8'h19, 8'h00, st, rd);
        check("t2_rstall", st, 0);
        check("t2_rdata", rd, 8'h41);
        check("t2_hit", hit_count, 2);
        check("t2_sat_hit", s_hit_count, 2);

        // Dirty eviction: write-back of 0x0C before fetch of 0x1C.
        log_q.delete();
        cpu_access(1'b0, 8'h39, 8'h00, st, rd);
        check("t3_stall", st, 5);
        check("t3_rdata", rd, 8'hA5);
        check("t3_log_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t3_wb_kind", log_q[0].wr, 1);
            check("t3_wb_addr", log_q[0].addr, 7'h0C);
            check("t3_wb_data", log_q[0].data, 16'h4100);
            check("t3_rd_kind", log_q[1].wr, 0);
            check("t3_rd_addr", log_q[1].addr, 7'h1C);
        end
        check("t3_counts", {hit_count, miss_count}, {16'd2, 16'd2});

        // Flush with lines 0 and 5 dirty.
        cpu_access(1'b1, 8'h01, 8'h11, st, rd);
        check("t4_w0_stall", st, 3);
        cpu_access(1'b1, 8'h0A, 8'h22, st, rd);
        check("t4_w5_stall", st, 3);
        log_q.delete();
        done_cnt = 0;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        check("t4_flush_busy", busy_wait, 1);
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        check("t4_done_seen", done_cnt > 0, 1);
        @(negedge clk); #1;
        check("t4_done_pulses", done_cnt, 1);
        check("t4_idle_busy", busy_wait, 0);
        check("t4_log_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t4_wb0", {log_q[0].wr, log_q[0].addr, log_q[0].data}, {1'b1, 7'h00, 16'h1100});
            check("t4_wb1", {log_q[1].wr, log_q[1].addr, log_q[1].data}, {1'b1, 7'h05, 16'h0022});
        end
        cpu_access(1'b0, 8'h01, 8'h00, st, rd);
        check("t4_r0_stall", st, 0);
        check("t4_r0_data", rd, 8'h11);
        cpu_access(1'b0, 8'h0A, 8'h00, st, rd);
        check("t4_r5_stall", st, 0);
        check("t4_r5_data", rd, 8'h22);
        check("t4_counts", {hit_count, miss_count}, {16'd4, 16'd4});

        // Illegal read+write: no activity, no state change.
        log_q.delete();
        @(negedge clk);
        address = 8'h01; write_data = 8'hFF; read = 1'b1; write = 1'b1;
        #1;
        check("t6_busy", busy_wait, 0);
        repeat (3) @(negedge clk);
        #1;
        check("t6_mem_rw", {mem_read, mem_write}, 0);
        check("t6_log_n", log_q.size(), 0);
        check("t6_counts", {hit_count, miss_count}, {16'd4, 16'd4});
        read = 1'b0; write = 1'b0;
        cpu_access(1'b0, 8'h01, 8'h00, st, rd);
        check("t6_unwritten", rd, 8'h11);

        // Saturation: fifth hit leaves the 2-bit counter at 3.
        check("t7_hit5", hit_count, 5);
        check("t7_sat_hit", s_hit_count, 3);
        check("t7_sat_miss", s_miss_count, 3);

        // Reset during ALLOCATE.
        mem_stall = 1'b1;
        @(negedge clk);
        address = 8'h19; read = 1'b1;
        for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
        #1;
        check("t5_alloc_req", mem_read, 1);
        @(negedge clk);
        rst = 1'b1; read = 1'b0;
        @(negedge clk); #1;
        check("t5_rst_rw", {mem_read, mem_write, flush_done, busy_wait}, 0);
        check("t5_rst_addr", mem_address, 0);
        check("t5_rst_counts", {hit_count, miss_count}, 0);
        rst = 1'b0; mem_stall = 1'b0;
        cpu_access(1'b0, 8'h19, 8'h00, st, rd);
        check("t5_remiss_stall", st, 3);
        check("t5_remiss_data", rd, 8'h41);
        check("t5_miss", miss_count, 1);

        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_wb_param.md
# dcache_wb_param

Parametrised direct-mapped, write-back, write-allocate data cache between the CPU datapath (load/store unit) and the multi-cycle data memory. Successor to the fixed 8-line/2-byte-block cache:
- Line count, block size, data width and address width are parameters.
- A single registered FSM replaces the clock-level event waits.
- The memory side uses an explicit request/ready handshake.
- Adds whole-cache flush and saturating hit/miss counters.

## Interface
- ADDR_W, 8, CPU byte/word address width
- DATA_W, 8, CPU word width
- WORDS_PER_BLOCK, 2, words per line; power of two, ≥2
- LINES, 8, number of lines; power of two
- CNT_W, 16, width of statistics counters
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- read  in  1  CPU load request; level, held until busy_wait low
- write  in  1  CPU store request; level, held until busy_wait low
- address  in  ADDR_W  CPU word address: {tag, index, offset}
- write_data  in  DATA_W  store data
- read_data  out  DATA_W  load data; valid when read && !busy_wait
- busy_wait  out  1  CPU stall
- flush  in  1  one-cycle pulse: write back all dirty lines
- flush_done  out  1  one-cycle pulse when flush completes
- mem_read  out  1  block fetch request
- mem_write  out  1  block write-back request
- mem_address  out  ADDR_W−log2(WORDS_PER_BLOCK)  block address {tag, index}
- mem_write_data  out  DATA_W·WORDS_PER_BLOCK  write-back block; word 0 in LSBs
- mem_read_data  in  DATA_W·WORDS_PER_BLOCK  fetched block; sampled when mem_ready
- mem_ready  in  1  one-cycle completion pulse from memory
- hit_count, miss_count  out  CNT_W  saturating statistics counters

## Operation
- Address split (LSB up): offset = log2(WORDS_PER_BLOCK) bits, index = log2(LINES) bits, tag = rest.
- hit = valid[index] && tag_store[index]==tag.
- read && write both high: illegal; treated as no request, no state change.
- States: IDLE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- IDLE, hit:
  - Read: read_data = word[index][offset], combinational, busy_wait=0.
  - Write: word written and dirty set at the clock edge, busy_wait=0.
  - hit_count increments once per completed access.
- IDLE, miss: busy_wait=1 combinationally; miss_count increments once.
  - Victim dirty: go to WRITEBACK.
  - Victim clean: go to ALLOCATE.
- WRITEBACK:
  - mem_write=1, mem_address={tag_store[index], index}, mem_write_data=victim block.
  - On mem_ready: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - mem_read=1, mem_address={tag, index}.
  - On mem_ready: load the block, set the tag, valid=1, dirty=0, return to IDLE.
  - The access then completes as a hit; it is not counted as a hit.
- flush is accepted only in IDLE with no pending request; a pulse arriving otherwise is ignored.
- Flush sequence: FLUSH_SCAN walks the index from 0 to LINES−1.
  - Dirty line: go to FLUSH_WB; write back; clear dirty on mem_ready; return to scan.
  - After the last line, pulse flush_done and return to IDLE.
  - Valid bits are kept.
  - busy_wait=1 throughout the flush.
- Counters saturate at all-ones; no wrap.
- mem_read and mem_write are never both high.
- Requests are held stable from assertion until mem_ready.

## Timing
- Reset values: every output 0; state IDLE; all valid/dirty cleared; counters 0; data array contents don't-care.
- Reset mid-miss or mid-flush: next edge returns to IDLE, memory requests drop, dirty data is discarded.
- Hit: 0 stall cycles.
- Clean miss: 1 detect cycle + memory latency L + 1 cycle, then data is available.
- Dirty miss: adds L + 1.
- mem_* outputs are registered: asserted the cycle after the state is entered.
- Memory may return mem_ready no earlier than 1 cycle after the request.
- mem_ready outside WRITEBACK, ALLOCATE or FLUSH_WB is ignored.
- CPU must not change address or write_data while busy_wait=1.

## Structure
- Package dcache_pkg holds:
  - the state enum;
  - localparams OFF_W, IDX_W, TAG_W and BLK_W, derived with $clog2.
- One sub-module, dcache_line_store: data/tag/valid/dirty arrays with a combinational read port and a synchronous word/block write port.
- FSM and counters live in the top level.

## Test plan
- Defaults, after rst: read 0x19 → miss; mem_read with mem_address 0x0C; after ready with block {0x2D, 0x00}, read_data=0x2D; miss_count=1.
- Write 0x19 = 0x41, then read 0x19 → both hits with 0 stall; read_data=0x41; hit_count=2.
- Dirty eviction, continuing from the previous test with 0x19 dirty: read 0x39 → mem_write of block 0x0C with data {0x41, 0x00} first, then mem_read of block 0x1C; mem_read and mem_write are never both high.
- Flush with lines 0 and 5 dirty → exactly two write-backs, in index order; one flush_done pulse; a subsequent read of those addresses hits.
- Reset asserted during ALLOCATE → next cycle all outputs 0; a read of the same address misses again.
- Counter saturation with CNT_W=2: five hits → hit_count holds at 3.
- read and write both high → no memory activity, busy_wait=0, counters unchanged.
